drawing_mem_arbiter: RTL and testbench
======================================

# drawing_mem_arbiter

Round-robin arbiter that shares the single drawing-engine memory port (de_*) between NREQ drawing clients. It sits between the drawing units and the memory driver. It latches a grant and registers the selected request fields, so the forward path is glitch-free even when requests overlap. Acks and read data are steered back to the granted client only.

## Interface
- NREQ, 4: number of requesting clients (2..8)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-client request, bit i = client i
- ack  out  NREQ  per-client acknowledge, one-hot or zero
- rnw  in  NREQ  per-client read-not-write
- addr  in  NREQ*18  client i address in bits [18i+17:18i]
- nbyte  in  NREQ*4  client i active-low byte enables in bits [4i+3:4i]
- data  in  NREQ*32  client i write data in bits [32i+31:32i]
- rd_data  out  32  read data, broadcast to all clients
- de_req  out  1  request to memory driver
- de_ack  in  1  memory driver completion, one-cycle pulse
- de_rnw  out  1  registered read-not-write
- de_addr  out  18  registered address
- de_nbyte  out  4  registered byte enables
- de_data  out  32  registered write data
- de_rd_data  in  32  memory read data, valid in the de_ack cycle

## Operation
- Two states: IDLE and BUSY.
- IDLE, any req set:
  - pick a winner by round-robin, searching from (last+1) mod NREQ upward with wrap;
  - register grant, rnw/addr/nbyte/data of the winner, and last := winner;
  - go to BUSY.
- IDLE, no req set: stay in IDLE. de_ack is ignored in IDLE and all ack bits stay 0.
- BUSY:
  - de_req = 1; de_* fields hold their registered values;
  - ack[grant] = de_ack (combinational) and all other ack bits are 0;
  - on de_ack go to IDLE. Otherwise stay in BUSY, with no timeout.
- Requests that change during BUSY do not affect the grant or de_* fields.
- rd_data = de_rd_data (combinational). It is meaningful to a client only in the cycle its ack is high.
- Client rules:
  - hold req and its fields stable until the edge at which ack is sampled high, then drop req;
  - req may be reasserted in the very next cycle.
- de_ack held high for more than one cycle is treated as a single ack; the extra cycles fall in IDLE and are ignored.
- Reset values:
  - state IDLE; last = NREQ-1, so client 0 wins first;
  - de_req 0, ack all 0, de_rnw 1, de_addr 0, de_nbyte 4'hf, de_data 0.
- Reset asserted mid-transfer: de_req and ack drop immediately (asynchronously). The transfer is abandoned and the client must reissue it.

## Timing
- Request to de_req:
  - req rises in cycle n, is sampled at edge n+1, and de_req is high from cycle n+1;
  - de_ack arrives no earlier than cycle n+2, because the driver samples de_req at edge n+2.
- ack is coincident with de_ack (zero latency).
- IDLE is entered at the edge after de_ack. The next grant is made at the following edge, so there is one bubble cycle between back-to-back transfers.
- Maximum wait for any client: NREQ-1 other transfers (round-robin fairness).

## Configuration
- DRAWING_ARB_PRIO0_EN defined:
  - client 0 has absolute priority: if req[0] is set in IDLE, client 0 wins regardless of the round-robin pointer;
  - last is not updated on a client-0 win;
  - clients 1..NREQ-1 share round-robin among themselves (this is intended for display refresh).
- Not defined: pure round-robin across all NREQ clients, as described above.

## Structure
- Package drawing_arb_pkg:
  - ADDR_W=18, DATA_W=32, NBYTE_W=4;
  - state enum {ARB_IDLE, ARB_BUSY};
  - reset constants for the de_* fields.
- Sub-module drawing_arb_rr_pick: combinational round-robin picker.
  - inputs: req vector, last index;
  - outputs: winner index, valid;
  - parameterised by NREQ.
- The top level holds the FSM, field registers and ack steering.

## Test plan
- Reset then single request:
  - stimulus: req=4'b0100, addr2=18'h00123, rnw2=0, data2=32'hDEADBEEF, nbyte2=4'h0; driver pulses de_ack 3 cycles after de_req;
  - required: de_addr=18'h00123, de_data=32'hDEADBEEF, ack=4'b0100 only in the de_ack cycle, de_req low the cycle after.
- All four clients requesting continuously from reset: grant order 0,1,2,3,0,… with exactly one bubble cycle between transfers.
- Client 3 changes addr3 and drops req3 during client 1's BUSY phase: de_addr holds addr1 until de_ack and ack[3] stays 0.
- Read: rnw1=1, de_rd_data=32'hCAFE0001 in the de_ack cycle: rd_data=32'hCAFE0001 with ack=4'b0010. A de_ack pulse in IDLE produces ack=0.
- rst asserted while BUSY with client 2: de_req and ack go to 0 without waiting for an edge. After release, client 0 wins first if req=4'b0101.
- With DRAWING_ARB_PRIO0_EN, req0 held high continuously plus req1 and req3: client 0 wins every arbitration. When req0 drops, clients 1 and 3 alternate.

Source files
------------

// File: rtl/drawing_mem_arbiter_pkg.sv
// Shared widths, FSM state type and reset values for the drawing memory arbiter.
// Optional client-0 priority mode is selected with DRAWING_ARB_PRIO0_EN.
package drawing_arb_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 32;
  localparam int NBYTE_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam logic               RST_RNW   = 1'b1;
  localparam logic [ADDR_W-1:0]  RST_ADDR  = '0;
  localparam logic [NBYTE_W-1:0] RST_NBYTE = 4'hf;
  localparam logic [DATA_W-1:0]  RST_DATA  = '0;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drawing_mem_arbiter_if.sv
// Client bundle plus drawing-engine memory port shared by the arbiter.
// slave = arbiter view, master = clients/driver view.
interface drawing_mem_arbiter_if #(
  parameter int NREQ = 4
);
  import drawing_arb_pkg::*;

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         ack;
  logic [NREQ-1:0]         rnw;
  logic [NREQ*ADDR_W-1:0]  addr;
  logic [NREQ*NBYTE_W-1:0] nbyte;
  logic [NREQ*DATA_W-1:0]  data;
  logic [DATA_W-1:0]       rd_data;

  logic                    de_req;
  logic                    de_ack;
  logic                    de_rnw;
  logic [ADDR_W-1:0]       de_addr;
  logic [NBYTE_W-1:0]      de_nbyte;
  logic [DATA_W-1:0]       de_data;
  logic [DATA_W-1:0]       de_rd_data;

  modport slave (
    input  req, rnw, addr, nbyte, data,
    input  de_ack, de_rd_data,
    output ack, rd_data,
    output de_req, de_rnw, de_addr, de_nbyte, de_data
  );

  modport master (
    output req, rnw, addr, nbyte, data,
    output de_ack, de_rd_data,
    input  ack, rd_data,
    input  de_req, de_rnw, de_addr, de_nbyte, de_data
  );

endinterface

// File: rtl/drawing_arb_rr_pick.sv
// Combinational round-robin picker: first set request after last, with wrap.
module drawing_arb_rr_pick
  import drawing_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   win_o,
  output logic            valid_o
);

  logic [IW-1:0] ix;

  // Walk from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    ix      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      ix = IW'((int'(last_i) + k) % NREQ);
      if (req_i[ix]) begin
        win_o   = ix;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drawing_mem_arbiter.sv
// Round-robin arbiter sharing the drawing-engine memory port among NREQ clients.
// Define DRAWING_ARB_PRIO0_EN to give client 0 absolute priority.
module drawing_mem_arbiter
  import drawing_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic                  clk,
  input logic                  rst,
  drawing_mem_arbiter_if.slave bus
);

  localparam int IW = idx_w(NREQ);

  arb_state_e         state_q;
  logic [IW-1:0]      grant_q;
  logic [IW-1:0]      last_q;
  logic               rnw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [NBYTE_W-1:0] nbyte_q;
  logic [DATA_W-1:0]  data_q;

  logic [NREQ-1:0]    rr_req;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic [IW-1:0]      sel_d;
  logic               sel_vld_d;
  logic               upd_last_d;
  logic               rnw_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [NBYTE_W-1:0] nbyte_d;
  logic [DATA_W-1:0]  data_d;

  drawing_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i   (rr_req),
    .last_i  (last_q),
    .win_o   (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef DRAWING_ARB_PRIO0_EN
  // Client 0 bypasses the pointer; the rest rotate among themselves.
  assign rr_req = {bus.req[NREQ-1:1], 1'b0};

  always_comb begin
    sel_d      = pick_idx;
    sel_vld_d  = pick_vld;
    upd_last_d = 1'b1;
    if (bus.req[0]) begin
      sel_d      = '0;
      sel_vld_d  = 1'b1;
      upd_last_d = 1'b0;
    end
  end
`else
  assign rr_req     = bus.req;
  assign sel_d      = pick_idx;
  assign sel_vld_d  = pick_vld;
  assign upd_last_d = 1'b1;
`endif

  always_comb begin
    rnw_d   = RST_RNW;
    addr_d  = RST_ADDR;
    nbyte_d = RST_NBYTE;
    data_d  = RST_DATA;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_d == IW'(i)) begin
        rnw_d   = bus.rnw[i];
        addr_d  = bus.addr[i*ADDR_W +: ADDR_W];
        nbyte_d = bus.nbyte[i*NBYTE_W +: NBYTE_W];
        data_d  = bus.data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      rnw_q   <= RST_RNW;
      addr_q  <= RST_ADDR;
      nbyte_q <= RST_NBYTE;
      data_q  <= RST_DATA;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (sel_vld_d) begin
            state_q <= ARB_BUSY;
            grant_q <= sel_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            nbyte_q <= nbyte_d;
            data_q  <= data_d;
            if (upd_last_d) last_q <= sel_d;
          end
        end
        ARB_BUSY: begin
          if (bus.de_ack) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Ack follows de_ack with zero latency, steered to the latched grant.
  always_comb begin
    bus.ack = '0;
    if (state_q == ARB_BUSY && bus.de_ack) bus.ack[grant_q] = 1'b1;
  end

  assign bus.de_req   = (state_q == ARB_BUSY);
  assign bus.de_rnw   = rnw_q;
  assign bus.de_addr  = addr_q;
  assign bus.de_nbyte = nbyte_q;
  assign bus.de_data  = data_q;
  assign bus.rd_data  = bus.de_rd_data;

endmodule

// File: tb/tb_drawing_mem_arbiter.sv
// Scoreboard bench for drawing_mem_arbiter (NREQ=4).
module tb_drawing_mem_arbiter;

  typedef struct {
    logic        rnw;
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [3:0]  ack;
    logic        rnw;
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic [31:0] data;
    logic [31:0] rd;
  } exp_t;

  logic clk;
  logic rst;

  drawing_mem_arbiter_if #(.NREQ(4)) bus ();

  drawing_mem_arbiter #(.NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors = 0;
  int   miscomp = 0;
  txn_t cq[4][$];
  exp_t exp_q[$];
  int   cnt;
  int   lat;
  bit   drv_en;
  logic [31:0] rd_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic add(int i, logic rnw, logic [17:0] a,
                     logic [3:0] nb, logic [31:0] d);
    txn_t t;
    t.rnw = rnw; t.addr = a; t.nbyte = nb; t.data = d;
    cq[i].push_back(t);
  endtask

  task automatic exp_push(int i, logic rnw, logic [17:0] a,
                          logic [3:0] nb, logic [31:0] d,
                          logic [31:0] rd);
    exp_t e;
    e.ack = 4'b0001 << i;
    e.rnw = rnw; e.addr = a; e.nbyte = nb; e.data = d; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // One clock: sample acks, then update driver model and clients after the edge.
  task automatic step();
    logic [3:0] a;
    txn_t t;
    @(negedge clk);
    a = bus.ack;
    @(posedge clk);
    #1;
    if (bus.de_ack) begin
      bus.de_ack = 1'b0;
      bus.de_rd_data = 32'h5A5A5A5A;
      cnt = 0;
    end else if (drv_en && bus.de_req) begin
      cnt++;
      if (cnt >= lat) begin
        bus.de_ack = 1'b1;
        bus.de_rd_data = rd_val;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (a[i]) begin
        if (cq[i].size() > 0) void'(cq[i].pop_front());
        bus.req[i] = 1'b0;
      end
      if (!bus.req[i] && cq[i].size() > 0) begin
        t = cq[i][0];
        bus.req[i] = 1'b1;
        bus.rnw[i] = t.rnw;
        bus.addr[i*18 +: 18] = t.addr;
        bus.nbyte[i*4 +: 4] = t.nbyte;
        bus.data[i*32 +: 32] = t.data;
      end
    end
  endtask

  task automatic wait_done(int max);
    for (int c = 0; c < max && exp_q.size() > 0; c++) step();
    chk("timeout_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.rnw = '0;
    bus.addr = '0;
    bus.nbyte = '1;
    bus.data = '0;
    bus.de_ack = 1'b0;
    bus.de_rd_data = '0;
    for (int i = 0; i < 4; i++) cq[i].delete();
    exp_q.delete();
    cnt = 0;
    lat = 4;
    drv_en = 1'b1;
    rd_val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares every ack cycle with the scoreboard, plus bubble timing.
  initial begin
    int   phase;
    bit   b2b;
    exp_t e;
    phase = 0;
    b2b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        continue;
      end
      if (phase == 1) begin
        chk("bubble_de_req", 64'(bus.de_req), 64'd0);
        chk("bubble_ack", 64'(bus.ack), 64'd0);
        phase = b2b ? 2 : 0;
      end else if (phase == 2) begin
        chk("b2b_de_req", 64'(bus.de_req), 64'd1);
        phase = 0;
      end
      if (|bus.ack) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ack", 64'(bus.ack), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack", 64'(bus.ack), 64'(e.ack));
          chk("de_addr", 64'(bus.de_addr), 64'(e.addr));
          chk("de_rnw", 64'(bus.de_rnw), 64'(e.rnw));
          chk("de_nbyte", 64'(bus.de_nbyte), 64'(e.nbyte));
          chk("de_data", 64'(bus.de_data), 64'(e.data));
          chk("rd_data", 64'(bus.rd_data), 64'(e.rd));
          b2b = exp_q.size() > 0;
          phase = 1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;

    // Reset values, then a single write from client 2.
    do_reset();
    chk("rst_de_req", 64'(bus.de_req), 64'd0);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_de_rnw", 64'(bus.de_rnw), 64'd1);
    chk("rst_de_addr", 64'(bus.de_addr), 64'd0);
    chk("rst_de_nbyte", 64'(bus.de_nbyte), 64'hf);
    chk("rst_de_data", 64'(bus.de_data), 64'd0);
    add(2, 1'b0, 18'h00123, 4'h0, 32'hDEADBEEF);
    exp_push(2, 1'b0, 18'h00123, 4'h0, 32'hDEADBEEF, 32'h0);
    wait_done(40);

    // All four continuously, fastest driver: order 0,1,2,3,0,1,2,3.
    do_reset();
    lat = 2;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        add(i, 1'b0, 18'(i * 256 + k), 4'(i), 32'h1000_0000 * i + k);
        exp_push(i, 1'b0, 18'(i * 256 + k), 4'(i),
                 32'h1000_0000 * i + k, 32'h0);
      end
    wait_done(80);

    // Client 3 wiggles during client 1's transfer.
    do_reset();
    add(1, 1'b0, 18'h00111, 4'h3, 32'h11111111);
    exp_push(1, 1'b0, 18'h00111, 4'h3, 32'h11111111, 32'h0);
    step();
    step();
    bus.req[3] = 1'b1;
    bus.addr[3*18 +: 18] = 18'h00333;
    step();
    chk("hold_addr_a", 64'(bus.de_addr), 64'h00111);
    bus.addr[3*18 +: 18] = 18'h003FF;
    step();
    chk("hold_addr_b", 64'(bus.de_addr), 64'h00111);
    bus.req[3] = 1'b0;
    wait_done(40);
    chk("no_grant3", 64'(bus.de_req), 64'd0);

    // Stray de_ack in IDLE, then a read.
    do_reset();
    drv_en = 1'b0;
    step();
    bus.de_ack = 1'b1;
    #1 chk("idle_ack", 64'(bus.ack), 64'd0);
    step();
    chk("idle_de_req", 64'(bus.de_req), 64'd0);
    drv_en = 1'b1;
    rd_val = 32'hCAFE0001;
    add(1, 1'b1, 18'h00456, 4'h0, 32'h0);
    exp_push(1, 1'b1, 18'h00456, 4'h0, 32'h0, 32'hCAFE0001);
    wait_done(40);

    // Async reset while client 2 is busy.
    do_reset();
    drv_en = 1'b0;
    add(2, 1'b0, 18'h00222, 4'h0, 32'h22222222);
    step();
    step();
    step();
    chk("busy_de_req", 64'(bus.de_req), 64'd1);
    bus.de_ack = 1'b1;
    #1 chk("pre_rst_ack", 64'(bus.ack), 64'h4);
    #1 rst = 1'b1;
    #1 chk("async_de_req", 64'(bus.de_req), 64'd0);
    chk("async_ack", 64'(bus.ack), 64'd0);
    do_reset();
    add(0, 1'b0, 18'h000A0, 4'h1, 32'h0A0A0A0A);
    add(2, 1'b0, 18'h002A2, 4'h2, 32'h2A2A2A2A);
    exp_push(0, 1'b0, 18'h000A0, 4'h1, 32'h0A0A0A0A, 32'h0);
    exp_push(2, 1'b0, 18'h002A2, 4'h2, 32'h2A2A2A2A, 32'h0);
    wait_done(60);

    // Clients 0 (three), 1 and 3 (two each) all requesting.
    do_reset();
    for (int k = 0; k < 3; k++) add(0, 1'b0, 18'(16'h00A0 + k), 4'h0, 32'hA0 + k);
    for (int k = 0; k < 2; k++) add(1, 1'b0, 18'(16'h00B0 + k), 4'h0, 32'hB0 + k);
    for (int k = 0; k < 2; k++) add(3, 1'b0, 18'(16'h00D0 + k), 4'h0, 32'hD0 + k);
`ifdef DRAWING_ARB_PRIO0_EN
    exp_push(0, 1'b0, 18'h000A0, 4'h0, 32'hA0, 32'h0);
    exp_push(0, 1'b0, 18'h000A1, 4'h0, 32'hA1, 32'h0);
    exp_push(0, 1'b0, 18'h000A2, 4'h0, 32'hA2, 32'h0);
    exp_push(1, 1'b0, 18'h000B0, 4'h0, 32'hB0, 32'h0);
    exp_push(3, 1'b0, 18'h000D0, 4'h0, 32'hD0, 32'h0);
    exp_push(1, 1'b0, 18'h000B1, 4'h0, 32'hB1, 32'h0);
    exp_push(3, 1'b0, 18'h000D1, 4'h0, 32'hD1, 32'h0);
`else
    exp_push(0, 1'b0, 18'h000A0, 4'h0, 32'hA0, 32'h0);
    exp_push(1, 1'b0, 18'h000B0, 4'h0, 32'hB0, 32'h0);
    exp_push(3, 1'b0, 18'h000D0, 4'h0, 32'hD0, 32'h0);
    exp_push(0, 1'b0, 18'h000A1, 4'h0, 32'hA1, 32'h0);
    exp_push(1, 1'b0, 18'h000B1, 4'h0, 32'hB1, 32'h0);
    exp_push(3, 1'b0, 18'h000D1, 4'h0, 32'hD1, 32'h0);
    exp_push(0, 1'b0, 18'h000A2, 4'h0, 32'hA2, 32'h0);
`endif
    wait_done(120);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule
